// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine arbiter.
package gcd_pkg;
   localparam int DEF_N_REQ = 4;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 16;
   localparam int ID_W      = $clog2(DEF_N_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;
endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
   import gcd_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   localparam logic [ID_W:0] N_LIM = N_REQ[ID_W:0];

   logic [ID_W:0] cand_s;

   // scan ptr, ptr+1, ... modulo N_REQ and keep the first hit
   always_comb begin
      grant  = {N_REQ{1'b0}};
      idx    = {ID_W{1'b0}};
      any    = 1'b0;
      cand_s = {(ID_W+1){1'b0}};
      for (int off = 0; off < N_REQ; off++) begin
         cand_s = {1'b0, ptr} + off[ID_W:0];
         if (cand_s >= N_LIM) begin
            cand_s = cand_s - N_LIM;
         end else begin
            cand_s = cand_s;
         end
         if (!any && req[cand_s[ID_W-1:0]]) begin
            any                       = 1'b1;
            idx                       = cand_s[ID_W-1:0];
            grant[cand_s[ID_W-1:0]]   = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD engine between N_REQ requesters, one job in flight;
// zero operands are answered directly since the engine cannot finish them.
module gcd_arbiter
   import gcd_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_bits,
   output logic [CNT_W-1:0]       rsp_cycles,
   output logic                   gcd_in_valid,
   input  logic                   gcd_in_ready,
   output logic [WIDTH-1:0]       gcd_in_a,
   output logic [WIDTH-1:0]       gcd_in_b,
   input  logic                   gcd_out_valid,
   input  logic [WIDTH-1:0]       gcd_out_bits,
   output logic                   busy
);

   localparam int               ID_W   = $clog2(N_REQ);
   localparam logic [ID_W:0]    N_LIM  = N_REQ[ID_W:0];
   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
   localparam logic [N_REQ-1:0] ZERO_N = {N_REQ{1'b0}};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   state_e             state_r;
   logic [ID_W-1:0]    rr_ptr_r;
   logic [ID_W-1:0]    id_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   rsp_bits_r;
   logic [CNT_W-1:0]   rsp_cycles_r;
   logic [N_REQ-1:0]   rsp_valid_r;
   logic               gcd_in_valid_r;
   logic               busy_r;

   logic [N_REQ-1:0]   pick_grant_s;
   logic [ID_W-1:0]    pick_idx_s;
   logic               pick_any_s;
   logic [WIDTH-1:0]   pick_a_s;
   logic [WIDTH-1:0]   pick_b_s;
   logic               bypass_s;
   logic [WIDTH-1:0]   bypass_val_s;
   logic [ID_W:0]      ptr_sum_s;
   logic [ID_W:0]      ptr_wrap_s;
   logic [ID_W-1:0]    next_ptr_s;
   logic [N_REQ-1:0]   id_oh_s;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_r),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   assign pick_a_s = req_a[pick_idx_s*WIDTH +: WIDTH];
   assign pick_b_s = req_b[pick_idx_s*WIDTH +: WIDTH];
   assign id_oh_s  = {{(N_REQ-1){1'b0}}, 1'b1} << id_r;

   // bypass result and next round-robin pointer for the current winner
   always_comb begin
      bypass_s     = (pick_a_s == ZERO_W) || (pick_b_s == ZERO_W);
      bypass_val_s = (pick_a_s == ZERO_W) ? pick_b_s : pick_a_s;
      ptr_sum_s    = {1'b0, pick_idx_s} + {{ID_W{1'b0}}, 1'b1};
      if (ptr_sum_s >= N_LIM) begin
         ptr_wrap_s = ptr_sum_s - N_LIM;
      end else begin
         ptr_wrap_s = ptr_sum_s;
      end
      next_ptr_s = ptr_wrap_s[ID_W-1:0];
   end

   // accept pulse is only offered while idle and out of reset
   always_comb begin
      if (!reset && (state_r == IDLE)) begin
         req_ready = pick_grant_s;
      end else begin
         req_ready = ZERO_N;
      end
   end

   // job FSM with operand/result registers and latency counter
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= IDLE;
         rr_ptr_r       <= {ID_W{1'b0}};
         id_r           <= {ID_W{1'b0}};
         a_r            <= ZERO_W;
         b_r            <= ZERO_W;
         cnt_r          <= ZERO_C;
         rsp_bits_r     <= ZERO_W;
         rsp_cycles_r   <= ZERO_C;
         rsp_valid_r    <= ZERO_N;
         gcd_in_valid_r <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_any_s) begin
                  id_r     <= pick_idx_s;
                  a_r      <= pick_a_s;
                  b_r      <= pick_b_s;
                  rr_ptr_r <= next_ptr_s;
                  cnt_r    <= ZERO_C;
                  busy_r   <= 1'b1;
                  if (bypass_s) begin
                     rsp_bits_r   <= bypass_val_s;
                     rsp_cycles_r <= ZERO_C;
                     rsp_valid_r  <= pick_grant_s;
                     state_r      <= RESP;
                  end else begin
                     gcd_in_valid_r <= 1'b1;
                     state_r        <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt_r <= sat_inc(cnt_r);
               if (gcd_in_ready) begin
                  gcd_in_valid_r <= 1'b0;
                  state_r        <= WAIT;
               end
            end
            WAIT: begin
               cnt_r <= sat_inc(cnt_r);
               if (gcd_out_valid) begin
                  rsp_bits_r   <= gcd_out_bits;
                  rsp_cycles_r <= sat_inc(cnt_r);
                  rsp_valid_r  <= id_oh_s;
                  state_r      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready[id_r]) begin
                  rsp_valid_r <= ZERO_N;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               rsp_valid_r    <= ZERO_N;
               gcd_in_valid_r <= 1'b0;
               busy_r         <= 1'b0;
               state_r        <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid    = rsp_valid_r;
   assign rsp_bits     = rsp_bits_r;
   assign rsp_cycles   = rsp_cycles_r;
   assign gcd_in_valid = gcd_in_valid_r;
   assign gcd_in_a     = a_r;
   assign gcd_in_b     = b_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a fixed-latency GCD engine model.
module tb_gcd_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  rsp_valid;
   logic [3:0]  rsp_ready;
   logic [15:0] rsp_bits;
   logic [15:0] rsp_cycles;
   logic        gcd_in_valid;
   logic        gcd_in_ready;
   logic [15:0] gcd_in_a;
   logic [15:0] gcd_in_b;
   logic        gcd_out_valid;
   logic [15:0] gcd_out_bits;
   logic        busy;

   logic        stall;
   logic        eng_busy;
   logic [1:0]  eng_lat;
   logic [15:0] eng_res;
   int          iv_cnt;
   int          pass_cnt;
   int          total_cnt;

   gcd_arbiter #(.N_REQ(4), .WIDTH(16), .CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bits(rsp_bits), .rsp_cycles(rsp_cycles),
      .gcd_in_valid(gcd_in_valid), .gcd_in_ready(gcd_in_ready), .gcd_in_a(gcd_in_a), .gcd_in_b(gcd_in_b),
      .gcd_out_valid(gcd_out_valid), .gcd_out_bits(gcd_out_bits), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] gcd_f(input logic [15:0] x0, input logic [15:0] y0);
      logic [15:0] x, y, t;
      x = x0;
      y = y0;
      for (int i = 0; i < 40 && y != 16'd0; i++) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // engine: result pulse on the third cycle after accept
   assign gcd_in_ready  = !eng_busy && !stall;
   assign gcd_out_valid = eng_busy && (eng_lat == 2'd0);
   assign gcd_out_bits  = eng_res;

   always_ff @(posedge clock) begin
      if (reset) begin
         eng_busy <= 1'b0;
         eng_lat  <= 2'd0;
         eng_res  <= 16'd0;
      end else if (!eng_busy) begin
         if (gcd_in_valid && gcd_in_ready) begin
            eng_busy <= 1'b1;
            eng_lat  <= 2'd2;
            eng_res  <= gcd_f(gcd_in_a, gcd_in_b);
         end
      end else if (eng_lat == 2'd0) begin
         eng_busy <= 1'b0;
      end else begin
         eng_lat <= eng_lat - 2'd1;
      end
   end

   always @(posedge clock) if (gcd_in_valid) iv_cnt <= iv_cnt + 1;

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; req_valid = 4'd0; rsp_ready = 4'd0; stall = 1'b0;
      req_a = 64'd0; req_b = 64'd0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_rsp();
      for (int k = 0; k < 60 && rsp_valid == 4'd0; k++) @(negedge clock);
   endtask

   task automatic run_job(input int id, input logic [15:0] a, input logic [15:0] b,
                          output logic [3:0] gnt, output logic [3:0] rv,
                          output logic [15:0] bits, output logic [15:0] cyc);
      @(negedge clock);
      req_valid[id] = 1'b1;
      req_a[id*16 +: 16] = a;
      req_b[id*16 +: 16] = b;
      #1 gnt = req_ready;
      @(negedge clock);
      req_valid[id] = 1'b0;
      wait_rsp();
      rv = rsp_valid; bits = rsp_bits; cyc = rsp_cycles;
      rsp_ready[id] = 1'b1;
      @(negedge clock);
      rsp_ready[id] = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt += 6;
      if (req_ready !== 4'd0) $display("FAIL reset_req_ready got %h want 0", req_ready); else pass_cnt++;
      if (rsp_valid !== 4'd0) $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); else pass_cnt++;
      if (gcd_in_valid !== 1'b0) $display("FAIL reset_gcd_in_valid got %b want 0", gcd_in_valid); else pass_cnt++;
      if (rsp_bits !== 16'd0) $display("FAIL reset_rsp_bits got %0d want 0", rsp_bits); else pass_cnt++;
      if (rsp_cycles !== 16'd0) $display("FAIL reset_rsp_cycles got %0d want 0", rsp_cycles); else pass_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_single();
      logic [3:0] g, rv; logic [15:0] bits, cyc;
      do_reset();
      run_job(0, 16'd48, 16'd18, g, rv, bits, cyc);
      total_cnt += 5;
      if (g !== 4'b0001) $display("FAIL single_grant got %b want 0001", g); else pass_cnt++;
      if (rv !== 4'b0001) $display("FAIL single_rsp_valid got %b want 0001", rv); else pass_cnt++;
      if (bits !== 16'd6) $display("FAIL single_bits got %0d want 6", bits); else pass_cnt++;
      if (cyc !== 16'd4) $display("FAIL single_cycles got %0d want 4", cyc); else pass_cnt++;
      if (busy !== 1'b0) $display("FAIL single_busy_drop got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_fairness();
      logic [3:0]  exp_g [5];
      logic [15:0] exp_b [4];
      logic [3:0]  g;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_b = '{16'd6, 16'd25, 16'd1, 16'd6};
      do_reset();
      @(negedge clock);
      req_a = {16'd270, 16'd17, 16'd100, 16'd48};
      req_b = {16'd192, 16'd5, 16'd75, 16'd18};
      req_valid = 4'hf;
      #1;
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 20 && req_ready == 4'd0; k++) @(negedge clock);
         g = req_ready;
         total_cnt++;
         if (g !== exp_g[n]) $display("FAIL fair_grant%0d got %b want %b", n, g, exp_g[n]); else pass_cnt++;
         @(negedge clock);
         wait_rsp();
         total_cnt += 2;
         if (rsp_valid !== exp_g[n]) $display("FAIL fair_rsp_valid%0d got %b want %b", n, rsp_valid, exp_g[n]); else pass_cnt++;
         if (rsp_bits !== exp_b[n % 4]) $display("FAIL fair_bits%0d got %0d want %0d", n, rsp_bits, exp_b[n % 4]); else pass_cnt++;
         rsp_ready = exp_g[n];
         @(negedge clock);
         rsp_ready = 4'd0;
         if (n == 4) req_valid = 4'd0;
      end
   endtask

   task automatic test_bypass();
      logic [3:0] g, rv; logic [15:0] bits, cyc;
      logic [15:0] av [3];
      logic [15:0] bv [3];
      logic [15:0] ev [3];
      int iv0;
      av = '{16'd0, 16'd35, 16'd0};
      bv = '{16'd21, 16'd0, 16'd0};
      ev = '{16'd21, 16'd35, 16'd0};
      do_reset();
      iv0 = iv_cnt;
      for (int n = 0; n < 3; n++) begin
         run_job(2, av[n], bv[n], g, rv, bits, cyc);
         total_cnt += 4;
         if (g !== 4'b0100) $display("FAIL bypass_grant%0d got %b want 0100", n, g); else pass_cnt++;
         if (rv !== 4'b0100) $display("FAIL bypass_rsp_valid%0d got %b want 0100", n, rv); else pass_cnt++;
         if (bits !== ev[n]) $display("FAIL bypass_bits%0d got %0d want %0d", n, bits, ev[n]); else pass_cnt++;
         if (cyc !== 16'd0) $display("FAIL bypass_cycles%0d got %0d want 0", n, cyc); else pass_cnt++;
      end
      total_cnt++;
      if (iv_cnt - iv0 !== 0) $display("FAIL bypass_no_issue got %0d want 0", iv_cnt - iv0); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset();
      @(negedge clock);
      req_a[15:0] = 16'd48; req_b[15:0] = 16'd18; req_valid = 4'b0001;
      @(negedge clock);
      req_a[31:16] = 16'd9; req_b[31:16] = 16'd6; req_valid = 4'b0010;
      wait_rsp();
      rsp_ready = 4'b1110;
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if (req_ready !== 4'd0 || rsp_bits !== 16'd6 || rsp_valid !== 4'b0001)
            $display("FAIL bp_hold%0d got rr=%b bits=%0d rv=%b want 0000/6/0001", i, req_ready, rsp_bits, rsp_valid);
         else pass_cnt++;
         @(negedge clock);
      end
      rsp_ready = 4'b0001;
      @(negedge clock);
      rsp_ready = 4'd0;
      #1;
      total_cnt++;
      if (req_ready !== 4'b0010) $display("FAIL bp_next_grant got %b want 0010", req_ready); else pass_cnt++;
      @(negedge clock);
      req_valid = 4'd0;
      wait_rsp();
      total_cnt += 2;
      if (rsp_valid !== 4'b0010) $display("FAIL bp_rsp_valid got %b want 0010", rsp_valid); else pass_cnt++;
      if (rsp_bits !== 16'd3) $display("FAIL bp_bits got %0d want 3", rsp_bits); else pass_cnt++;
      rsp_ready = 4'b0010;
      @(negedge clock);
      rsp_ready = 4'd0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clock);
      req_a[15:0] = 16'd1000; req_b[15:0] = 16'd3; req_valid = 4'b0001;
      @(negedge clock);
      req_valid = 4'd0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      total_cnt += 5;
      if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else pass_cnt++;
      if (rsp_valid !== 4'd0) $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
      if (gcd_in_valid !== 1'b0) $display("FAIL mid_gcd_in_valid got %b want 0", gcd_in_valid); else pass_cnt++;
      if (rsp_bits !== 16'd0) $display("FAIL mid_rsp_bits got %0d want 0", rsp_bits); else pass_cnt++;
      if (req_ready !== 4'd0) $display("FAIL mid_req_ready got %b want 0", req_ready); else pass_cnt++;
      reset = 1'b0;
      req_a[15:0] = 16'd9; req_b[15:0] = 16'd6;
      req_a[31:16] = 16'd10; req_b[31:16] = 16'd4;
      req_valid = 4'b0011;
      #1;
      total_cnt++;
      if (req_ready !== 4'b0001) $display("FAIL mid_ptr_zero got %b want 0001", req_ready); else pass_cnt++;
      @(negedge clock);
      req_valid = 4'b0010;
      wait_rsp();
      total_cnt += 2;
      if (rsp_valid !== 4'b0001) $display("FAIL mid_new_rsp_valid got %b want 0001", rsp_valid); else pass_cnt++;
      if (rsp_bits !== 16'd3) $display("FAIL mid_new_bits got %0d want 3", rsp_bits); else pass_cnt++;
      rsp_ready = 4'b0001; req_valid = 4'd0;
      @(negedge clock);
      rsp_ready = 4'd0;
   endtask

   task automatic test_stall();
      do_reset();
      @(negedge clock);
      stall = 1'b1;
      req_a[15:0] = 16'd48; req_b[15:0] = 16'd18; req_valid = 4'b0001;
      @(negedge clock);
      req_valid = 4'd0;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if (gcd_in_valid !== 1'b1 || gcd_in_a !== 16'd48 || gcd_in_b !== 16'd18)
            $display("FAIL stall_hold%0d got v=%b a=%0d b=%0d want 1/48/18", i, gcd_in_valid, gcd_in_a, gcd_in_b);
         else pass_cnt++;
         @(negedge clock);
      end
      stall = 1'b0;
      wait_rsp();
      total_cnt += 3;
      if (rsp_valid !== 4'b0001) $display("FAIL stall_rsp_valid got %b want 0001", rsp_valid); else pass_cnt++;
      if (rsp_bits !== 16'd6) $display("FAIL stall_bits got %0d want 6", rsp_bits); else pass_cnt++;
      if (rsp_cycles !== 16'd9) $display("FAIL stall_cycles got %0d want 9", rsp_cycles); else pass_cnt++;
      rsp_ready = 4'b0001;
      @(negedge clock);
      rsp_ready = 4'd0;
   endtask

   initial begin
      pass_cnt = 0; total_cnt = 0;
      reset = 1'b1; stall = 1'b0; req_valid = 4'd0; rsp_ready = 4'd0;
      req_a = 64'd0; req_b = 64'd0;
      test_reset();
      test_single();
      test_fairness();
      test_bypass();
      test_backpressure();
      test_reset_mid();
      test_stall();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
